lvt_live_value_table: RTL and testbench

//  - Write-side bookkeeping for the 2-write/2-read LVT register file: records, per register address,

---
 rtl/lvt_live_value_table_pkg.sv | 37 +++
 rtl/lvt_live_value_table_if.sv | 38 +++
 rtl/lvt_live_value_table_read_port.sv | 72 +++++++
 rtl/lvt_live_value_table.sv | 72 +++++++
 tb/tb_lvt_live_value_table.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/lvt_live_value_table_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lvt_live_value_table_pkg
// Description : Shared types and constants for the live value table.
//               The optional build macro LVT_WRITE_BYPASS_EN is consumed in
//               lvt_read_port and does not affect this package.
// Revision    : 1.0  initial release
// ============================================================================
package lvt_live_value_table_pkg;

    // Default register address width; the table tracks 2**ADDR_WIDTH entries.
    localparam int LVT_ADDR_WIDTH  = 5;

    // A table entry names a write bank. Two banks need only one bit.
    localparam int LVT_ENTRY_WIDTH = 1;

    typedef logic [LVT_ENTRY_WIDTH-1:0] lvt_entry_t;

    localparam lvt_entry_t c_BANK_0 = 1'b0;
    localparam lvt_entry_t c_BANK_1 = 1'b1;

    // Same-cycle write resolution for one entry: port 1 beats port 0, and an
    // entry nobody writes keeps its current bank.
    function automatic lvt_entry_t lvt_resolve(
        input logic       hit_0,
        input logic       hit_1,
        input lvt_entry_t current
    );
        lvt_entry_t result;
        result = current;
        if (hit_0) result = c_BANK_0;
        if (hit_1) result = c_BANK_1;
        return result;
    endfunction

endpackage : lvt_live_value_table_pkg
`default_nettype wire

// File: rtl/lvt_live_value_table_if.sv
`default_nettype none
// ============================================================================
// Module      : lvt_live_value_table_if
// Description : Write/read port bundle of the live value table. The master
//               side issues writes and read addresses and receives the
//               per-read-port bank selectors; the slave side is the table.
// Revision    : 1.0  initial release
// ============================================================================
interface lvt_live_value_table_if
    import lvt_live_value_table_pkg::*;
#(
    parameter int ADDR_WIDTH = LVT_ADDR_WIDTH
);
    logic                  write_enable_0;
    logic [ADDR_WIDTH-1:0] write_addr_0;
    logic                  write_enable_1;
    logic [ADDR_WIDTH-1:0] write_addr_1;
    logic [ADDR_WIDTH-1:0] read_addr_0;
    logic [ADDR_WIDTH-1:0] read_addr_1;
    lvt_entry_t            read_bank_0;
    lvt_entry_t            read_bank_1;

    modport master (
        output write_enable_0, write_addr_0,
        output write_enable_1, write_addr_1,
        output read_addr_0,    read_addr_1,
        input  read_bank_0,    read_bank_1
    );

    modport slave (
        input  write_enable_0, write_addr_0,
        input  write_enable_1, write_addr_1,
        input  read_addr_0,    read_addr_1,
        output read_bank_0,    read_bank_1
    );

endinterface : lvt_live_value_table_if
`default_nettype wire

// File: rtl/lvt_live_value_table_read_port.sv
`default_nettype none
// ============================================================================
// Module      : lvt_read_port
// Description : One read port of the live value table: looks up the entry
//               for read_addr, optionally forwards same-cycle writes, and
//               registers the result so it lines up with the 1-cycle bank
//               RAM read.
//               Build macro LVT_WRITE_BYPASS_EN: when defined, a write to the
//               addressed entry in the same cycle is forwarded (write-first
//               RAMs); when undefined, the pre-write value is returned
//               (read-first RAMs).
// Revision    : 1.0  initial release
// ============================================================================
module lvt_read_port
    import lvt_live_value_table_pkg::*;
#(
    parameter int ADDR_WIDTH = LVT_ADDR_WIDTH,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  wire logic                  clock,
    input  wire logic                  reset_n,
    input  wire logic [ADDR_WIDTH-1:0] read_addr,
    input  wire lvt_entry_t [DEPTH-1:0] table_entries,
    input  wire logic                  write_enable_0,
    input  wire logic [ADDR_WIDTH-1:0] write_addr_0,
    input  wire logic                  write_enable_1,
    input  wire logic [ADDR_WIDTH-1:0] write_addr_1,
    output lvt_entry_t                 read_bank
);

    lvt_entry_t w_stored;
    lvt_entry_t w_next_bank;
    lvt_entry_t r_read_bank;

    assign w_stored = table_entries[read_addr];

`ifdef LVT_WRITE_BYPASS_EN
    logic w_hit_0;
    logic w_hit_1;

    assign w_hit_0 = write_enable_0 && (write_addr_0 == read_addr);
    assign w_hit_1 = write_enable_1 && (write_addr_1 == read_addr);

    // Forward a same-cycle write to this address, port 1 taking priority.
    always_comb begin
        w_next_bank = lvt_resolve(w_hit_0, w_hit_1, w_stored);
    end
`else
    // Write ports are only needed for forwarding; tie them off here.
    logic w_unused_write_ports;
    assign w_unused_write_ports = &{1'b0, write_enable_0, write_addr_0,
                                   write_enable_1, write_addr_1};

    // Read-first: report the table as it stood before this cycle's writes.
    always_comb begin
        w_next_bank = w_stored;
    end
`endif

    // Output register, re-sampled every cycle; reset reports bank 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_read_bank <= c_BANK_0;
        end else begin
            r_read_bank <= w_next_bank;
        end
    end

    assign read_bank = r_read_bank;

endmodule : lvt_read_port
`default_nettype wire

// File: rtl/lvt_live_value_table.sv
`default_nettype none
// ============================================================================
// Module      : lvt_live_value_table
// Description : Live value table for a 2-write/2-read LVT register file.
//               Records which write bank holds the live value of each
//               register and supplies a registered bank selector per read
//               port. The table is a flop array so that the asynchronous
//               reset clears every entry.
//               Build macro LVT_WRITE_BYPASS_EN selects write-first read
//               behaviour (see lvt_read_port).
// Revision    : 1.0  initial release
// ============================================================================
module lvt_live_value_table
    import lvt_live_value_table_pkg::*;
#(
    parameter int ADDR_WIDTH = LVT_ADDR_WIDTH,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  wire logic             clock,
    input  wire logic             reset_n,
    lvt_live_value_table_if.slave bus
);

    lvt_entry_t [DEPTH-1:0] r_table;

    // Table update; the port-1 assignment comes last so it wins a same-address
    // collision. A reset arriving with a write discards that write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_table <= {DEPTH{c_BANK_0}};
        end else begin
            if (bus.write_enable_0) begin
                r_table[bus.write_addr_0] <= c_BANK_0;
            end
            if (bus.write_enable_1) begin
                r_table[bus.write_addr_1] <= c_BANK_1;
            end
        end
    end

    lvt_read_port #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_read_port_0 (
        .clock          (clock),
        .reset_n        (reset_n),
        .read_addr      (bus.read_addr_0),
        .table_entries  (r_table),
        .write_enable_0 (bus.write_enable_0),
        .write_addr_0   (bus.write_addr_0),
        .write_enable_1 (bus.write_enable_1),
        .write_addr_1   (bus.write_addr_1),
        .read_bank      (bus.read_bank_0)
    );

    lvt_read_port #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_read_port_1 (
        .clock          (clock),
        .reset_n        (reset_n),
        .read_addr      (bus.read_addr_1),
        .table_entries  (r_table),
        .write_enable_0 (bus.write_enable_0),
        .write_addr_0   (bus.write_addr_0),
        .write_enable_1 (bus.write_enable_1),
        .write_addr_1   (bus.write_addr_1),
        .read_bank      (bus.read_bank_1)
    );

endmodule : lvt_live_value_table
`default_nettype wire

// File: tb/tb_lvt_live_value_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_lvt_live_value_table
// Description : Directed self-checking bench for lvt_live_value_table.
//               Expected values follow the LVT_WRITE_BYPASS_EN setting of
//               the build.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lvt_live_value_table;

    localparam int         ADDR_WIDTH = 5;
    localparam logic [0:0] EXP_B0     = 1'b0;
    localparam logic [0:0] EXP_B1     = 1'b1;

`ifdef LVT_WRITE_BYPASS_EN
    localparam logic [0:0] EXP_BYPASS = EXP_B0;
`else
    localparam logic [0:0] EXP_BYPASS = EXP_B1;
`endif

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    lvt_live_value_table_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    lvt_live_value_table #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [0:0] observed,
                         input logic [0:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_writes();
        bus.write_enable_0 = 1'b0;
        bus.write_enable_1 = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        bus.write_enable_0 = 1'b0;
        bus.write_addr_0   = '0;
        bus.write_enable_1 = 1'b0;
        bus.write_addr_1   = '0;
        bus.read_addr_0    = '0;
        bus.read_addr_1    = '0;

        // Reset state
        step();
        check("reset_rb0", bus.read_bank_0, EXP_B0);
        check("reset_rb1", bus.read_bank_1, EXP_B0);
        reset_n = 1'b1;
        step();

        // Single write on port 1 to entry 7
        bus.write_enable_1 = 1'b1;
        bus.write_addr_1   = 5'd7;
        step();
        idle_writes();
        bus.read_addr_0 = 5'd7;
        bus.read_addr_1 = 5'd6;
        step();
        check("single_wr_rb0_addr7", bus.read_bank_0, EXP_B1);
        check("single_wr_rb1_addr6", bus.read_bank_1, EXP_B0);
        bus.read_addr_1 = 5'd7;
        step();
        check("single_wr_rb1_addr7", bus.read_bank_1, EXP_B1);

        // Asynchronous reset mid-cycle clears outputs without a clock edge
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("async_reset_rb0", bus.read_bank_0, EXP_B0);
        check("async_reset_rb1", bus.read_bank_1, EXP_B0);
        @(negedge clock);
        reset_n = 1'b1;

        // Every entry reads bank 0 after reset (entry 7 included)
        for (int a = 0; a < 32; a++) begin
            bus.read_addr_0 = 5'(a);
            bus.read_addr_1 = 5'(31 - a);
            step();
            check($sformatf("sweep_rb0_%0d", a), bus.read_bank_0, EXP_B0);
            check($sformatf("sweep_rb1_%0d", 31 - a), bus.read_bank_1, EXP_B0);
        end

        // Collision on entry 12: port 1 wins
        bus.write_enable_0 = 1'b1;
        bus.write_addr_0   = 5'd12;
        bus.write_enable_1 = 1'b1;
        bus.write_addr_1   = 5'd12;
        step();
        idle_writes();
        bus.read_addr_0 = 5'd12;
        step();
        check("collision_rb0_addr12", bus.read_bank_0, EXP_B1);
        bus.write_enable_0 = 1'b1;
        bus.write_addr_0   = 5'd12;
        step();
        idle_writes();
        step();
        check("port0_rewrite_addr12", bus.read_bank_0, EXP_B0);

        // Disabled port does not modify the table
        bus.write_enable_1 = 1'b1;
        bus.write_addr_1   = 5'd20;
        step();
        idle_writes();
        bus.write_addr_0 = 5'd20;
        bus.read_addr_0  = 5'd20;
        step();
        step();
        check("disabled_port0_addr20", bus.read_bank_0, EXP_B1);

        // Same-cycle write/read on entry 3 which holds bank 1
        bus.write_enable_1 = 1'b1;
        bus.write_addr_1   = 5'd3;
        step();
        idle_writes();
        bus.read_addr_1 = 5'd3;
        step();
        check("bypass_pre_addr3", bus.read_bank_1, EXP_B1);
        bus.write_enable_0 = 1'b1;
        bus.write_addr_0   = 5'd3;
        step();
        check("bypass_same_cycle_addr3", bus.read_bank_1, EXP_BYPASS);
        idle_writes();
        step();
        check("bypass_after_addr3", bus.read_bank_1, EXP_B0);

        // Dual distinct writes, then dual reads; entry 1 first set to bank 1
        bus.write_enable_1 = 1'b1;
        bus.write_addr_1   = 5'd1;
        step();
        bus.write_enable_0 = 1'b1;
        bus.write_addr_0   = 5'd1;
        bus.write_enable_1 = 1'b1;
        bus.write_addr_1   = 5'd31;
        step();
        idle_writes();
        bus.read_addr_0 = 5'd1;
        bus.read_addr_1 = 5'd31;
        step();
        check("dual_rb0_addr1", bus.read_bank_0, EXP_B0);
        check("dual_rb1_addr31", bus.read_bank_1, EXP_B1);

        // Both read ports on the same entry
        bus.read_addr_0 = 5'd31;
        step();
        check("shared_rb0_addr31", bus.read_bank_0, EXP_B1);
        check("shared_rb1_addr31", bus.read_bank_1, EXP_B1);

        // Reset asserted on the same edge as a port-1 write to entry 5
        bus.write_enable_1 = 1'b1;
        bus.write_addr_1   = 5'd5;
        @(posedge clock);
        reset_n = 1'b0;
        #1;
        idle_writes();
        @(negedge clock);
        reset_n = 1'b1;
        bus.read_addr_0 = 5'd5;
        bus.read_addr_1 = 5'd31;
        step();
        check("reset_drop_write_addr5", bus.read_bank_0, EXP_B0);
        check("reset_clears_addr31", bus.read_bank_1, EXP_B0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule : tb_lvt_live_value_table
`default_nettype wire
